// File: rtl/pmem_arbiter_if.sv
// Bundle of the icache, dcache and cacheline-adaptor pmem signals seen by the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of whatever
// drives both caches and the adaptor, such as a testbench.
interface pmem_arbiter_if #(
  parameter int s_line = 256,
  parameter int s_addr = 32
);
  logic              i_pmem_read;
  logic [s_addr-1:0] i_pmem_address;
  logic [s_line-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [s_addr-1:0] d_pmem_address;
  logic [s_line-1:0] d_pmem_wdata;
  logic [s_line-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              mem_read;
  logic              mem_write;
  logic [s_addr-1:0] mem_address;
  logic [s_line-1:0] mem_wdata;
  logic [s_line-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write,
           d_pmem_address, d_pmem_wdata, mem_rdata, mem_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write,
           d_pmem_address, d_pmem_wdata, mem_rdata, mem_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one cacheline-adaptor port between the icache and dcache miss paths.
// One line transaction is in flight at a time. Ties are resolved round-robin.
// A dcache writeback chains straight into its refill read, so an icache fetch
// can never split a dirty-miss sequence.
module pmem_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input logic          clk,
  input logic          rst,
  pmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] I_READ  = 2'd1;
  localparam logic [1:0] D_READ  = 2'd2;
  localparam logic [1:0] D_WRITE = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [s_addr-1:0] zero_addr = '0;
  localparam logic [s_line-1:0] zero_line = '0;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant;
  logic       last_grant_next;
  logic       i_req;
  logic       d_req;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  // State and round-robin memory. Reset leaves last_grant at D, so the first tie goes to the icache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Next-state logic. A writeback whose refill is already waiting chains into D_READ, skipping IDLE.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_grant == GRANT_D)) begin
          state_next = I_READ;
        end else if (d_req) begin
          state_next = bus.d_pmem_write ? D_WRITE : D_READ;
        end
      end
      I_READ: begin
        if (bus.mem_resp) begin
          state_next      = IDLE;
          last_grant_next = GRANT_I;
        end
      end
      D_READ: begin
        if (bus.mem_resp) begin
          state_next      = IDLE;
          last_grant_next = GRANT_D;
        end
      end
      D_WRITE: begin
        if (bus.mem_resp) begin
          state_next      = bus.d_pmem_read ? D_READ : IDLE;
          last_grant_next = GRANT_D;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Adaptor command and cache responses, decoded from state and the current inputs. Address and data are muxed, never latched.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = zero_addr;
    bus.mem_wdata   = zero_line;
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
    case (state)
      I_READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = bus.i_pmem_address;
        bus.i_pmem_resp = bus.mem_resp;
      end
      D_READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = bus.d_pmem_address;
        bus.d_pmem_resp = bus.mem_resp;
      end
      D_WRITE: begin
        bus.mem_write   = 1'b1;
        bus.mem_address = bus.d_pmem_address;
        bus.mem_wdata   = bus.d_pmem_wdata;
        bus.d_pmem_resp = bus.mem_resp;
      end
      default: ;
    endcase
  end

  // Both caches see the adaptor line at all times. Only their own resp strobe qualifies it.
  always_comb begin
    bus.i_pmem_rdata = bus.mem_rdata;
    bus.d_pmem_rdata = bus.mem_rdata;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter.
// Runs a per-cycle vector table, then hand-written multi-cycle sequences.
module tb_pmem_arbiter;

  localparam logic [31:0]  I_ADDR  = 32'h0000_1040;
  localparam logic [31:0]  D_ADDR  = 32'h0000_2000;
  localparam logic [31:0]  D_ADDR2 = 32'h0000_3000;
  localparam logic [255:0] WDATA   = {8{32'h1234_5678}};
  localparam logic [255:0] RDATA5  = {32{8'hA5}};

  typedef struct {
    logic [4:0]  stim;    // {rst, i_read, d_read, d_write, mem_resp}
    logic [3:0]  exp;     // {mem_read, mem_write, i_resp, d_resp}
    logic [31:0] e_addr;
    logic        e_wdata; // 1: mem_wdata must equal WDATA, 0: must be zero
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[16];

  pmem_arbiter_if #(.s_line(256), .s_addr(32)) bus ();

  pmem_arbiter #(.s_line(256), .s_addr(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock. Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] stim, input logic [255:0] rdata);
    rst              = stim[4];
    bus.i_pmem_read  = stim[3];
    bus.d_pmem_read  = stim[2];
    bus.d_pmem_write = stim[1];
    bus.mem_resp     = stim[0];
    bus.mem_rdata    = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    apply_stimulus(5'b10000, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int first, resp_cycle, icount, dcount, ngrant;
    logic [3:0] grant_exp;
    logic       got_d;
    logic [255:0] rd;

    checks = 0;
    errors = 0;
    bus.i_pmem_address = I_ADDR;
    bus.d_pmem_address = D_ADDR;
    bus.d_pmem_wdata   = WDATA;

    // Reset with both requests pending, round-robin ties, stray resp, illegal read+write, chained writeback.
    vecs[0]  = '{5'b11100, 4'b0000, 32'h0,  1'b0};
    vecs[1]  = '{5'b11100, 4'b0000, 32'h0,  1'b0};
    vecs[2]  = '{5'b01100, 4'b0000, 32'h0,  1'b0};
    vecs[3]  = '{5'b01100, 4'b1000, I_ADDR, 1'b0};
    vecs[4]  = '{5'b01101, 4'b1010, I_ADDR, 1'b0};
    vecs[5]  = '{5'b01100, 4'b0000, 32'h0,  1'b0};
    vecs[6]  = '{5'b01101, 4'b1001, D_ADDR, 1'b0};
    vecs[7]  = '{5'b01100, 4'b0000, 32'h0,  1'b0};
    vecs[8]  = '{5'b01101, 4'b1010, I_ADDR, 1'b0};
    vecs[9]  = '{5'b00001, 4'b0000, 32'h0,  1'b0};
    vecs[10] = '{5'b00000, 4'b0000, 32'h0,  1'b0};
    vecs[11] = '{5'b00110, 4'b0000, 32'h0,  1'b0};
    vecs[12] = '{5'b00110, 4'b0100, D_ADDR, 1'b1};
    vecs[13] = '{5'b00101, 4'b0101, D_ADDR, 1'b1};
    vecs[14] = '{5'b00101, 4'b1001, D_ADDR, 1'b0};
    vecs[15] = '{5'b00000, 4'b0000, 32'h0,  1'b0};

    for (int k = 0; k < 16; k++) begin
      rd = {8{32'hC0DE_0000 | 32'(k)}};
      apply_stimulus(vecs[k].stim, rd);
      @(negedge clk);
      check_output($sformatf("vec%0d_ctrl", k),
                   256'({bus.mem_read, bus.mem_write, bus.i_pmem_resp, bus.d_pmem_resp}),
                   256'(vecs[k].exp));
      check_output($sformatf("vec%0d_addr", k), 256'(bus.mem_address), 256'(vecs[k].e_addr));
      check_output($sformatf("vec%0d_wdata", k), bus.mem_wdata, vecs[k].e_wdata ? WDATA : 256'h0);
      check_output($sformatf("vec%0d_i_rdata", k), bus.i_pmem_rdata, rd);
      check_output($sformatf("vec%0d_d_rdata", k), bus.d_pmem_rdata, rd);
      next_cycle();
    end

    // Lone icache read: the adaptor answers 5 cycles after mem_read first appears.
    apply_stimulus(5'b01000, '0);
    first = -1; resp_cycle = -1; icount = 0; dcount = 0;
    for (int c = 0; c < 20; c++) begin
      bus.mem_resp  = (first >= 0 && c == first + 5);
      bus.mem_rdata = bus.mem_resp ? RDATA5 : '0;
      @(negedge clk);
      if (bus.mem_read && first < 0) first = c;
      if (bus.i_pmem_resp) begin
        icount++;
        resp_cycle = c;
        check_output("lone_i_rdata", bus.i_pmem_rdata, RDATA5);
      end
      if (bus.d_pmem_resp) dcount++;
      next_cycle();
      if (icount > 0) bus.i_pmem_read = 1'b0;
    end
    check_output("lone_i_resp_pulses", 256'(icount), 256'(1));
    check_output("lone_i_resp_cycle", 256'(resp_cycle), 256'(first + 5));
    check_output("lone_d_resp_quiet", 256'(dcount), 256'(0));

    // Round-robin with both caches requesting; the adaptor answers each command immediately.
    apply_reset();
    apply_stimulus(5'b01100, '0);
    grant_exp = 4'b1010;
    ngrant = 0;
    for (int c = 0; c < 40 && ngrant < 4; c++) begin
      bus.mem_resp = bus.mem_read | bus.mem_write;
      @(negedge clk);
      check_output("rr_resp_exclusive", 256'(bus.i_pmem_resp & bus.d_pmem_resp), 256'(0));
      if (bus.i_pmem_resp || bus.d_pmem_resp) begin
        got_d = bus.d_pmem_resp;
        check_output($sformatf("rr_grant%0d", ngrant), 256'(got_d), 256'(grant_exp[ngrant]));
        check_output($sformatf("rr_addr%0d", ngrant), 256'(bus.mem_address),
                     256'(grant_exp[ngrant] ? D_ADDR : I_ADDR));
        ngrant++;
      end
      next_cycle();
    end
    check_output("rr_grant_count", 256'(ngrant), 256'(4));

    // Reset asserted 2 cycles into a writeback drops mem_write at once; the arbiter restarts in IDLE.
    apply_reset();
    apply_stimulus(5'b00010, '0);
    next_cycle();
    next_cycle();
    check_output("midrst_write_before", 256'(bus.mem_write), 256'(1));
    rst = 1'b1;
    #1;
    check_output("midrst_write_drop", 256'(bus.mem_write), 256'(0));
    check_output("midrst_addr_zero", 256'(bus.mem_address), 256'(0));
    check_output("midrst_wdata_zero", bus.mem_wdata, 256'h0);
    next_cycle();
    apply_stimulus(5'b01000, '0);
    @(negedge clk);
    check_output("midrst_idle_after", 256'({bus.mem_read, bus.mem_write}), 256'(0));
    next_cycle();
    @(negedge clk);
    check_output("midrst_then_iread", 256'({bus.mem_read, bus.mem_write}), 256'(2'b10));
    check_output("midrst_then_iaddr", 256'(bus.mem_address), 256'(I_ADDR));

    // Dirty miss: writeback 0x2000 chains into refill 0x3000 while the icache waits.
    apply_reset();
    bus.d_pmem_address = D_ADDR;
    apply_stimulus(5'b00010, '0);
    @(negedge clk);
    check_output("chain_idle", 256'({bus.mem_read, bus.mem_write}), 256'(0));
    next_cycle();
    bus.i_pmem_read = 1'b1;
    @(negedge clk);
    check_output("chain_write", 256'({bus.mem_read, bus.mem_write}), 256'(2'b01));
    check_output("chain_write_addr", 256'(bus.mem_address), 256'(D_ADDR));
    check_output("chain_write_data", bus.mem_wdata, WDATA);
    next_cycle();
    apply_stimulus(5'b01101, '0);
    bus.d_pmem_address = D_ADDR2;
    @(negedge clk);
    check_output("chain_write_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(2'b01));
    next_cycle();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    check_output("chain_refill_cmd", 256'({bus.mem_read, bus.mem_write}), 256'(2'b10));
    check_output("chain_refill_addr", 256'(bus.mem_address), 256'(D_ADDR2));
    next_cycle();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    check_output("chain_refill_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(2'b01));
    next_cycle();
    apply_stimulus(5'b01000, '0);
    @(negedge clk);
    check_output("chain_idle_gap", 256'({bus.mem_read, bus.mem_write}), 256'(0));
    next_cycle();
    @(negedge clk);
    check_output("chain_icache_after", 256'({bus.mem_read, bus.mem_write}), 256'(2'b10));
    check_output("chain_icache_addr", 256'(bus.mem_address), 256'(I_ADDR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbitrates the instruction cache and data cache miss paths onto the single shared physical-memory (cacheline adaptor) port. One 256-bit line transaction is in flight at a time. Simultaneous requests are granted round-robin. A data-cache writeback is chained directly into its refill read, so the dirty-miss sequence cannot be split by an instruction fetch. The arbiter sits between both cache controllers' `pmem_*` ports and the cacheline adaptor.

## Interface
- `s_line`, default 256: cacheline width in bits
- `s_addr`, default 32: address width in bits

Ports (all single-bit unless stated):
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `i_pmem_read` in 1: icache line read request; held until `i_pmem_resp`
- `i_pmem_address` in `s_addr`: icache line address
- `i_pmem_rdata` out `s_line`: read line returned to icache
- `i_pmem_resp` out 1: icache transaction complete
- `d_pmem_read` in 1: dcache line read request
- `d_pmem_write` in 1: dcache line writeback request
- `d_pmem_address` in `s_addr`: dcache line address
- `d_pmem_wdata` in `s_line`: writeback line
- `d_pmem_rdata` out `s_line`: read line returned to dcache
- `d_pmem_resp` out 1: dcache transaction complete
- `mem_read` out 1: read command to the adaptor
- `mem_write` out 1: write command to the adaptor
- `mem_address` out `s_addr`: address to the adaptor
- `mem_wdata` out `s_line`: write line to the adaptor
- `mem_rdata` in `s_line`: line from the adaptor
- `mem_resp` in 1: adaptor completion, one cycle per transaction

## Operation
- The FSM has four states: IDLE, I_READ, D_READ and D_WRITE. State is registered; all outputs are decoded from state plus the current-cycle inputs.
- IDLE:
  - No memory command is issued.
  - The arbiter samples requests. A dcache request is `d_pmem_read | d_pmem_write`.
  - Only icache requesting: next state is I_READ.
  - Only dcache requesting: next state is D_WRITE if `d_pmem_write`, else D_READ. Write wins if both dcache lines are high, which is illegal but defined.
  - Both caches requesting: grant the requester not named by `last_grant`.
- I_READ:
  - `mem_read`=1, `mem_address`=`i_pmem_address`.
  - On `mem_resp`: `i_pmem_resp`=1 that cycle, `last_grant`<=I, next state IDLE.
- D_READ:
  - `mem_read`=1, `mem_address`=`d_pmem_address`.
  - On `mem_resp`: `d_pmem_resp`=1, `last_grant`<=D, next state IDLE.
- D_WRITE:
  - `mem_write`=1, `mem_address`=`d_pmem_address`, `mem_wdata`=`d_pmem_wdata`.
  - On `mem_resp`: `d_pmem_resp`=1 and `last_grant`<=D.
  - If `d_pmem_read` is high in that same cycle (refill chained after writeback), next state is D_READ with no IDLE cycle. The icache is not considered. Otherwise next state is IDLE.
- Read data: `i_pmem_rdata` and `d_pmem_rdata` are both driven from `mem_rdata` combinationally at all times. Only the `*_resp` strobe qualifies them.
- Resp gating: `mem_resp` arriving in IDLE is ignored. No `*_resp` is raised and the state does not change.
- Idle drive: in IDLE, `mem_address` and `mem_wdata` are 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, `last_grant`=D, so the first tie goes to the icache.
  - All outputs read 0: `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, `i_pmem_resp`, `d_pmem_resp`.
  - Reset mid-transaction abandons the transaction. The adaptor and both caches are reset by the same `rst`.
- Grant latency:
  - A request seen in IDLE at cycle N puts the memory command on the bus at cycle N+1.
  - `*_resp` is asserted in the same cycle as `mem_resp`. Completion and IDLE return happen at the edge that ends that cycle.
- Back-to-back:
  - After any completion to IDLE, the next grant's command starts two cycles after the `mem_resp` cycle.
  - A chained writeback-to-refill starts its read in the cycle immediately after the write's `mem_resp`.
- Handshake: requesters hold the request, address and wdata stable until their `*_resp`. The arbiter never latches address or data; it only muxes them.
- Exclusivity: `mem_read` and `mem_write` are never both 1. At most one `*_resp` is 1 in any cycle.

## Test plan
- Reset with requests pending:
  - Stimulus: raise `rst` with `i_pmem_read`=1 and `d_pmem_read`=1, release at cycle 2.
  - Required: all outputs 0 during reset. Cycle 3: state moves to I_READ on the tie. Cycle 4: `mem_read`=1, `mem_address`=`i_pmem_address`.
- Lone icache read:
  - Stimulus: address 0x0000_1040; adaptor returns `mem_rdata`=all-0xA5 with `mem_resp` 5 cycles after `mem_read`.
  - Required: `i_pmem_resp` pulses exactly 1 cycle with rdata all-0xA5; `d_pmem_resp` stays 0.
- Round-robin on simultaneous requests:
  - Stimulus: both caches hold read requests continuously.
  - Required: grants alternate I, D, I, D; `mem_address` alternates between the two addresses; no cycle has both resps.
- Dirty-miss chain:
  - Stimulus: dcache writes 0x0000_2000 with wdata 0x1234…, icache requesting throughout. At the write's `mem_resp` the dcache drops write and raises read to 0x0000_3000.
  - Required: `mem_read` at 0x0000_3000 on the next cycle; the icache is granted only after the read completes.
- Stray and illegal inputs:
  - Stimulus: `mem_resp` pulsed while in IDLE.
  - Required: no resp output and no state change.
  - Stimulus: `d_pmem_read`=`d_pmem_write`=1.
  - Required: D_WRITE is granted.
- Reset mid-transaction:
  - Stimulus: assert `rst` 2 cycles into D_WRITE.
  - Required: `mem_write` drops in the same cycle as `rst` rises, and state is IDLE after release.
